// File: rtl/conv_pkg.sv
// Shared constants, FSM states and packing helpers for the rate-1/2 encoder.
// Holds default generator polynomials per constraint length (octal).
package conv_pkg;

    localparam int K_MAX = 7;
    localparam int M_MAX = K_MAX - 1;

    // Default generator pairs (G0/G1, octal) for the common lengths.
    localparam int G0_K3 = 'o7;
    localparam int G1_K3 = 'o5;
    localparam int G0_K5 = 'o23;
    localparam int G1_K5 = 'o35;
    localparam int G0_K7 = 'o171;
    localparam int G1_K7 = 'o133;

    // Four 2-bit symbols per byte, s0 in [1:0] .. s3 in [7:6].
    localparam int SYM_W      = 2;
    localparam int SYMS_PER_B = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_WAIT,
        S_TAIL,
        S_FLUSH,
        S_DRAIN
    } state_e;

    // Place a symbol into its slot of a packed byte.
    function automatic logic [7:0] place_sym(
        input logic [1:0] sym,
        input logic [1:0] slot
    );
        logic [7:0] v;
        v = {6'd0, sym};
        return v << {slot, 1'b0};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder step: state + input bit -> 2-bit symbol + next state.
// Ports: state_i/bit_i in, sym_o {g0,g1} and state_o out.
module conv_enc_core
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic [K_MAX-2:0] state_i,
    input  logic             bit_i,
    output logic [1:0]       sym_o,
    output logic [K_MAX-2:0] state_o
);

    localparam int RM = (1 << K) - 1;
    localparam int SM = (1 << (K - 1)) - 1;

    localparam logic [K_MAX-1:0] R_MASK = RM[K_MAX-1:0];
    localparam logic [K_MAX-2:0] S_MASK = SM[K_MAX-2:0];
    localparam logic [K_MAX-1:0] G0     = G0_OCT[K_MAX-1:0] & R_MASK;
    localparam logic [K_MAX-1:0] G1     = G1_OCT[K_MAX-1:0] & R_MASK;

    logic [K_MAX-1:0] r;

    always_comb begin
        // r[K-1] is the oldest bit, r[0] the new one.
        r       = {state_i, bit_i} & R_MASK;
        sym_o   = {^(r & G0), ^(r & G1)};
        // Bits above M stay zero so shorter K reuse the K_MAX state.
        state_o = {state_i[K_MAX-3:0], bit_i} & S_MASK;
    end

endmodule

// File: rtl/conv_encoder_packer.sv
// Rate-1/2 convolutional encoder with tail insertion and symbol packing.
// Ports: byte input (in_*) valid/ready, packed symbol output (sym_*), busy, frame_done.
module conv_encoder_packer
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [3:0] in_nbits,
    output logic       in_ready,
    output logic [7:0] sym_data,
    output logic       sym_valid,
    output logic       sym_last,
    input  logic       sym_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int M = K - 1;

    state_e           st_q, st_d;
    logic [K_MAX-2:0] sr_q, sr_d;
    logic [7:0]       shf_q, shf_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       slot_q, slot_d;
    logic [7:0]       out_q, out_d;
    logic             ovld_q, ovld_d;
    logic             olast_q, olast_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             enc_bit;
    logic [1:0]       sym;
    logic [K_MAX-2:0] sr_nxt;
    logic             in_fire, out_fire, room, emit, step, fin;
    logic [3:0]       nb;

    conv_enc_core #(
        .K      (K),
        .G0_OCT (G0_OCT),
        .G1_OCT (G1_OCT)
    ) u_core (
        .state_i (sr_q),
        .bit_i   (enc_bit),
        .sym_o   (sym),
        .state_o (sr_nxt)
    );

    always_comb begin
        in_fire  = in_valid && rdy_q;
        out_fire = ovld_q && sym_ready;
        room     = !ovld_q || sym_ready;
        enc_bit  = (st_q == S_ENC) && shf_q[0];
        emit     = (st_q == S_ENC) || (st_q == S_TAIL);
        // Only the 4th symbol needs the output register; others never stall.
        step     = emit && ((slot_q != 2'd3) || room);
        nb       = (in_last && in_nbits != 4'd0 && in_nbits <= 4'd8)
                 ? in_nbits : 4'd8;
        fin      = 1'b0;

        st_d    = st_q;
        sr_d    = sr_q;
        shf_d   = shf_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        acc_d   = acc_q;
        slot_d  = slot_q;
        out_d   = out_q;
        ovld_d  = ovld_q;
        olast_d = olast_q;

        if (out_fire) begin
            ovld_d  = 1'b0;
            olast_d = 1'b0;
        end

        if (step) begin
            sr_d  = sr_nxt;
            cnt_d = cnt_q - 4'd1;
            shf_d = shf_q >> 1;
            if (slot_q == 2'd3) begin
                out_d   = acc_q | place_sym(sym, slot_q);
                ovld_d  = 1'b1;
                // Last tail symbol filling a byte makes it the final byte.
                olast_d = (st_q == S_TAIL) && (cnt_q == 4'd1);
                acc_d   = 8'd0;
                slot_d  = 2'd0;
            end else begin
                acc_d  = acc_q | place_sym(sym, slot_q);
                slot_d = slot_q + 2'd1;
            end
        end

        unique case (st_q)
            S_IDLE, S_WAIT: begin
                if (in_fire) begin
                    shf_d  = in_data;
                    cnt_d  = nb;
                    last_d = in_last;
                    st_d   = S_ENC;
                end
            end
            S_ENC: begin
                if (step && cnt_q == 4'd1) begin
                    if (last_q) begin
                        st_d  = S_TAIL;
                        cnt_d = M[3:0];
                    end else begin
                        st_d = S_WAIT;
                    end
                end
            end
            S_TAIL: begin
                if (step && cnt_q == 4'd1) begin
                    st_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_q == 2'd0) begin
                    // Final byte already sits in the output register.
                    if (out_fire) begin
                        fin = 1'b1;
                    end else begin
                        st_d = S_DRAIN;
                    end
                end else if (room) begin
                    out_d   = acc_q;
                    ovld_d  = 1'b1;
                    olast_d = 1'b1;
                    acc_d   = 8'd0;
                    slot_d  = 2'd0;
                    st_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    fin = 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase

        if (fin) begin
            st_d = S_IDLE;
            sr_d = '0;
        end
        done_d = fin;
        rdy_d  = (st_d == S_IDLE) || (st_d == S_WAIT);
        busy_d = (st_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= S_IDLE;
            sr_q    <= '0;
            shf_q   <= 8'd0;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
            acc_q   <= 8'd0;
            slot_q  <= 2'd0;
            out_q   <= 8'd0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sr_q    <= sr_d;
            shf_q   <= shf_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            slot_q  <= slot_d;
            out_q   <= out_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = rdy_q;
    assign sym_data   = out_q;
    assign sym_valid  = ovld_q;
    assign sym_last   = olast_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_conv_encoder_packer.sv
// Randomized scoreboard bench for conv_encoder_packer (K=5, 23/35).
// Reference encoder works on bit lists and integer state.
module tb_conv_encoder_packer;

    localparam int K  = 5;
    localparam int M  = K - 1;
    localparam int G0 = 'o23;
    localparam int G1 = 'o35;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [3:0] in_nbits = 4'd0;
    logic       in_ready;
    logic [7:0] sym_data;
    logic       sym_valid;
    logic       sym_last;
    logic       sym_ready = 1'b0;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int frames_sent = 0;
    int rdy_pct = 100;

    logic [8:0] mdl_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] fd [4];

    conv_encoder_packer #(
        .K      (K),
        .G0_OCT (G0),
        .G1_OCT (G1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_nbits   (in_nbits),
        .in_ready   (in_ready),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: list the frame bits, append M zeros, encode, pack by 4.
    task automatic run_model(input logic [7:0] d [4], input int nby,
                             input int nbits);
        int bits [$];
        int syms [$];
        int st, r, nb, n, v;
        mdl_q.delete();
        nb = (nbits == 0 || nbits > 8) ? 8 : nbits;
        for (int i = 0; i < nby; i++) begin
            n = (i == nby - 1) ? nb : 8;
            for (int j = 0; j < n; j++) bits.push_back(int'(d[i][j]));
        end
        for (int j = 0; j < M; j++) bits.push_back(0);
        st = 0;
        foreach (bits[i]) begin
            r = ((st << 1) | bits[i]) & ((1 << K) - 1);
            syms.push_back((($countones(r & G0) % 2) << 1)
                           | ($countones(r & G1) % 2));
            st = r & ((1 << M) - 1);
        end
        while (syms.size() % 4 != 0) syms.push_back(0);
        for (int i = 0; i < syms.size(); i += 4) begin
            v = syms[i] | (syms[i+1] << 2) | (syms[i+2] << 4)
              | (syms[i+3] << 6);
            mdl_q.push_back({(i + 4 == syms.size()), v[7:0]});
        end
    endtask

    task automatic expect_frame(input logic [7:0] d [4], input int nby,
                                input int nbits);
        run_model(d, nby, nbits);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        frames_sent++;
    endtask

    // Waits for in_ready (poking junk valid meanwhile), then one transfer.
    task automatic send_byte(input logic [7:0] d, input logic last,
                             input logic [3:0] nbits, input int gap);
        int t = 0;
        while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        while (!in_ready && t < 300) begin
            in_valid = 1'($urandom_range(1));
            in_data  = 8'($urandom);
            in_last  = 1'($urandom_range(1));
            in_nbits = 4'($urandom_range(15));
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_nbits = last ? nbits : 4'($urandom_range(15));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d [4], input int nby,
                              input int nbits, input int gap);
        expect_frame(d, nby, nbits);
        for (int i = 0; i < nby; i++)
            send_byte(d[i], (i == nby - 1), 4'(nbits), gap);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((n_done < frames_sent || exp_q.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("frame_done count", n_done, frames_sent);
        chk("exp queue drained", exp_q.size(), 0);
        chk("idle busy", busy, 0);
        chk("idle in_ready", in_ready, 1);
    endtask

    initial begin
        fork
            begin : rdy_drv
                forever begin
                    @(posedge clk); #1;
                    sym_ready = ($urandom_range(99) < rdy_pct);
                end
            end
            begin : mon
                logic       pstall;
                logic [7:0] pdata;
                logic       plast;
                logic [8:0] e;
                pstall = 1'b0;
                pdata  = 8'd0;
                plast  = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        pstall = 1'b0;
                    end else begin
                        if (pstall) begin
                            chk("stall valid", sym_valid, 1);
                            chk("stall data", sym_data, pdata);
                            chk("stall last", sym_last, plast);
                        end
                        if (sym_valid && sym_ready) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected byte", sym_data, 9'h1ff);
                            end else begin
                                e = exp_q.pop_front();
                                chk("sym_data", sym_data, e[7:0]);
                                chk("sym_last", sym_last, e[8]);
                            end
                        end
                        pstall = sym_valid && !sym_ready;
                        pdata  = sym_data;
                        plast  = sym_last;
                        if (frame_done) n_done++;
                    end
                end
            end
            begin : main
                int k;
                // Pin the reference against hand-encoded frames.
                fd = '{8'h01, 8'h00, 8'h00, 8'h00};
                run_model(fd, 1, 8);
                chk("model 01 size", mdl_q.size(), 3);
                chk("model 01 b0", mdl_q[0], 9'h05b);
                chk("model 01 b1", mdl_q[1], 9'h003);
                chk("model 01 b2", mdl_q[2], 9'h100);
                run_model(fd, 1, 1);
                chk("model 01n1 size", mdl_q.size(), 2);
                chk("model 01n1 b0", mdl_q[0], 9'h05b);
                chk("model 01n1 b1", mdl_q[1], 9'h103);
                fd[0] = 8'h00;
                run_model(fd, 1, 8);
                chk("model 00 size", mdl_q.size(), 3);
                chk("model 00 b2", mdl_q[2], 9'h100);

                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                chk("rst in_ready", in_ready, 1);
                chk("rst sym_valid", sym_valid, 0);
                chk("rst sym_last", sym_last, 0);
                chk("rst sym_data", sym_data, 0);
                chk("rst busy", busy, 0);
                chk("rst frame_done", frame_done, 0);

                // All-zero byte.
                send_frame(fd, 1, 8, 0);
                wait_idle();

                // 0x01 with first-output latency and busy.
                fd[0] = 8'h01;
                expect_frame(fd, 1, 8);
                send_byte(8'h01, 1'b1, 4'd8, 0);
                chk("busy after accept", busy, 1);
                k = 0;
                while (!sym_valid && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk("first sym latency", k, 4);
                wait_idle();

                // Partial last byte.
                send_frame(fd, 1, 1, 0);
                wait_idle();

                // Downstream stall.
                rdy_pct = 0;
                repeat (2) @(posedge clk);
                #1;
                expect_frame(fd, 1, 8);
                send_byte(8'h01, 1'b1, 4'd8, 0);
                k = 0;
                while (!sym_valid && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                for (int i = 0; i < 20; i++) begin
                    chk("stalled valid", sym_valid, 1);
                    chk("stalled data", sym_data, 8'h5b);
                    chk("stalled in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                rdy_pct = 100;
                wait_idle();

                // Reset after the first output byte.
                run_model(fd, 1, 8);
                exp_q.push_back(mdl_q[0]);
                send_byte(8'h01, 1'b1, 4'd8, 0);
                k = 0;
                while (!(sym_valid && sym_ready) && k < 20) begin
                    @(posedge clk); #1;
                    k++;
                end
                @(posedge clk); #1;
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                chk("mid rst sym_valid", sym_valid, 0);
                chk("mid rst busy", busy, 0);
                chk("mid rst in_ready", in_ready, 1);
                send_frame(fd, 1, 8, 0);
                wait_idle();

                // Two-byte frame 0xACE2, low byte first.
                fd = '{8'he2, 8'hac, 8'h00, 8'h00};
                send_frame(fd, 2, 8, 0);
                wait_idle();

                // Random frames, random gaps and backpressure.
                for (int f = 0; f < 40; f++) begin
                    for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
                    rdy_pct = $urandom_range(40, 100);
                    send_frame(fd, $urandom_range(1, 4),
                               $urandom_range(0, 8), $urandom_range(0, 50));
                    wait_idle();
                end
                rdy_pct = 100;
                repeat (4) @(posedge clk);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_encoder_packer.md
Name: conv_encoder_packer

Overview:
Rate-1/2 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder and produces exactly the symbol stream that decoder consumes.
- Input: data bytes, consumed LSB first, over a valid/ready handshake.
- Output: symbol bytes, 4 symbols per byte, s0 in [1:0] through s3 in [7:6].
- At frame end the block appends K-1 zero tail bits and zero-pads the final symbol byte.
- Sits between the host byte interface and the channel/decoder; also serves as the golden encoder in loopback benches.

Parameters:
K, 5, constraint length; legal values 3..7; memory M=K-1.
G0_OCT, 'o23, generator 0, octal; its MSB taps the oldest state bit.
G1_OCT, 'o35, generator 1, octal.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
in_data  in  8  data bits; bit 0 is encoded first.
in_valid  in  1  in_data/in_last/in_nbits are valid.
in_last  in  1  this byte ends the frame.
in_nbits  in  4  valid bits in the last byte, 1..8; 0 is treated as 8; ignored unless in_last.
in_ready  out  1  block can accept a data byte.
sym_data  out  8  packed symbol byte {s3,s2,s1,s0}.
sym_valid  out  1  sym_data is valid.
sym_last  out  1  this symbol byte is the frame's final byte.
sym_ready  in  1  downstream accepts the symbol byte.
busy  out  1  a frame is in progress.
frame_done  out  1  one-cycle pulse when the final symbol byte is accepted.

Behaviour:
Reset:
- rst=1 at any time, including mid-frame, clears all state on that clock edge.
- After reset: shift state=0, bit buffer empty, pack accumulator empty, output register empty, FSM=IDLE.
- Output values after reset: in_ready=1, sym_valid=0, sym_last=0, sym_data=0, busy=0, frame_done=0.
- No partial byte is emitted after a reset.

Handshakes:
- Input transfer happens on a cycle with in_valid&&in_ready.
- Output transfer happens on a cycle with sym_valid&&sym_ready.
- sym_data, sym_valid and sym_last stay stable while sym_valid=1 and sym_ready=0.

Encoding, one input bit per cycle when not stalled:
- r = {state[K-2:0], b}, K bits wide.
- sym[1] = ^(r & G0), sym[0] = ^(r & G1).
- Then state <= {state[K-3:0], b}.
- The state is sized for K=7 and its unused upper bits are held at 0.

FSM states:
- IDLE: in_ready=1. A transfer loads an 8-bit shift register and a bit count (8, or nbits if in_last), latches last, and moves to ENC. busy goes high from the next cycle.
- ENC: shifts one bit per cycle.
  - When the count reaches 0 and not last: go to IDLE-equivalent wait; in_ready=1, busy stays 1, state is preserved.
  - When the count reaches 0 and last: go to TAIL.
  - in_ready=0 throughout ENC.
- TAIL: encodes M zero bits, one per cycle, then goes to FLUSH.
- FLUSH:
  - If the accumulator holds 1..3 symbols, the remaining slots are padded with 00 and the byte is pushed with sym_last=1.
  - If the accumulator is empty, the byte pushed by the 4th symbol already carries sym_last=1.
  - Then go to DRAIN.
- DRAIN: waits for the last byte to be accepted, pulses frame_done, goes to IDLE, clears state to 0, busy=0.

Packing and stalls:
- The 4th symbol moves the accumulator into the single-entry output register.
- This is allowed if the register is empty or is being accepted in the same cycle.
- Otherwise encoding stalls and the symbol bit is not consumed.
- Full throughput: 1 symbol/cycle. First sym_valid appears 4 cycles after the first input accept.
- Symbol count per frame = N+M; byte count = ceil((N+M)/4).

Protocol violation:
- in_valid asserted while in_ready=0 is ignored.

Decomposition:
- Package conv_pkg:
  - K_MAX=7.
  - Default generator constants per K: 3 -> 7/5, 5 -> 23/35, 7 -> 171/133.
  - Symbol-packing bit positions.
  - FSM state enum.
- One natural sub-module: conv_enc_core, which takes the state plus one bit and returns the 2-bit symbol and the next state (combinational). The FSM, packer and output register stay in the top.

Test Plan:
- K=5, one byte 0x00, in_last, nbits=8 -> 3 symbol bytes 0x00,0x00,0x00; sym_last on the 3rd; one frame_done pulse.
- K=5, 0x01, in_last, nbits=8 -> bytes 0x5B, 0x03, 0x00.
- K=5, 0x01, in_last, nbits=1 -> bytes 0x5B, then 0x03 with sym_last=1 (padded).
- K=5, 0x01 with sym_ready held low for 20 cycles after the first sym_valid:
  - sym_data=0x5B stays stable.
  - in_ready=0 while stalled.
  - Final byte sequence is unchanged.
- Reset mid-frame: assert rst after the first output byte.
  - Next cycle: sym_valid=0, busy=0, in_ready=1.
  - A following 0x01 frame reproduces 0x5B, 0x03, 0x00.
- Loopback, K=3/5/7: 16-bit frame 0xACE2 (two bytes, 2nd in_last) fed into the Viterbi decoder -> decoded 0xACE2, 0 errors.
